// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared defaults, requester ids and tag-pipe entry layout for the multiplier arbiter
package mult_arb_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int LAT_DEF   = 1;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    valid;
        req_id_e id;
    } tag_t;
endpackage

// File: rtl/mult_tag_pipe.sv
// mult_tag_pipe: LAT-deep {valid, id} shift register that tracks ops through the shared multiplier
import mult_arb_pkg::*;

module mult_tag_pipe #(
    parameter int LAT = LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  tag_t din,
    output tag_t dout,
    output logic any_valid
);
    tag_t stage_q [LAT];
    tag_t stage_d [LAT];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < LAT; i++) stage_d[i] = stage_q[i-1];
        any_valid = 1'b0;
        for (int i = 0; i < LAT; i++) any_valid = any_valid | stage_q[i].valid;
    end

    // Advances only with the multiplier enable so tags stay aligned with its pipeline
    always_ff @(posedge clk or negedge reset)
        if (!reset) stage_q <= '{default: '0};
        else if (en) stage_q <= stage_d;

    assign dout = stage_q[LAT-1];
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one registered multiplier between two requesters
import mult_arb_pkg::*;

module mult_share_arbiter #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LAT   = LAT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 rsp0_valid,
    output logic [2*WIDTH-1:0]   rsp0_prod,
    output logic                 rsp1_valid,
    output logic [2*WIDTH-1:0]   rsp1_prod,
    output logic                 mult_en,
    output logic [WIDTH-1:0]     mult_a,
    output logic [WIDTH-1:0]     mult_b,
    input  logic [2*WIDTH-1:0]   mult_prod
);
    logic               rr_ptr_q, rr_ptr_d;
    logic               gnt0, gnt1, issue, pipe_busy;
    tag_t               pipe_in, pipe_out;
    logic               rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
    logic [2*WIDTH-1:0] rsp0_prod_q, rsp0_prod_d, rsp1_prod_q, rsp1_prod_d;

    always_comb begin
        // Grants are forced low while reset is held so nothing is accepted then
        gnt0 = reset && req0_valid && (!req1_valid || rr_ptr_q == REQ0);
        gnt1 = reset && req1_valid && (!req0_valid || rr_ptr_q == REQ1);
        issue = gnt0 || gnt1;
        rr_ptr_d = (gnt0 && req1_valid) ? REQ1 : (gnt1 && req0_valid) ? REQ0 : rr_ptr_q;
        mult_en = issue || pipe_busy;
        mult_a = gnt0 ? req0_a : gnt1 ? req1_a : '0;
        mult_b = gnt0 ? req0_b : gnt1 ? req1_b : '0;
        pipe_in.valid = issue;
        pipe_in.id = req_id_e'(gnt1);
        rsp0_valid_d = pipe_out.valid && pipe_out.id == REQ0;
        rsp1_valid_d = pipe_out.valid && pipe_out.id == REQ1;
        rsp0_prod_d = rsp0_valid_d ? mult_prod : rsp0_prod_q;
        rsp1_prod_d = rsp1_valid_d ? mult_prod : rsp1_prod_q;
    end

    mult_tag_pipe #(.LAT(LAT)) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .en        (mult_en),
        .din       (pipe_in),
        .dout      (pipe_out),
        .any_valid (pipe_busy)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            rr_ptr_q     <= REQ0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_prod_q  <= '0;
            rsp1_prod_q  <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_prod_q  <= rsp0_prod_d;
            rsp1_prod_q  <= rsp1_prod_d;
        end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_prod  = rsp0_prod_q;
    assign rsp1_prod  = rsp1_prod_q;
endmodule
